// File: rtl/pcie_p2s2p_link_pkg.sv
// Shared constants and types for the serial loopback link.
// COM is the idle/alignment symbol and never a data value.
package pcie_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [DATA_W-1:0] COM_SYM = 8'hBC;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DATA_W - 1);

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } rx_state_t;

endpackage

// File: rtl/pcie_p2s2p_link_if.sv
// Parallel-side handshake bundle plus serial probe.
// master = source/consumer, slave = the link.
interface pcie_p2s2p_link_if;
  import pcie_pkg::*;

  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              in_ready;
  logic              serial_out;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              locked;

  modport master (
    output valid_in,
    output data_in,
    input  in_ready,
    input  serial_out,
    input  data_out,
    input  valid_out,
    input  locked
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output in_ready,
    output serial_out,
    output data_out,
    output valid_out,
    output locked
  );

endinterface

// File: rtl/pcie_rx_des.sv
// Deserializer aligning on COM, then framing every
// DATA_W bits. Lock is sticky until reset.
module pcie_rx_des
  import pcie_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              locked_o
);

  rx_state_t         state_q;
  rx_state_t         state_d;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] rx_next;
  logic [CNT_W-1:0]  rx_cnt_q;
  logic [CNT_W-1:0]  rx_cnt_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              valid_q;
  logic              valid_d;

  assign rx_next  = {rx_shift_q[DATA_W-2:0], serial_i};
  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign locked_o = (state_q == LOCKED);

  // Alignment search and word framing.
  always_comb begin
    state_d  = state_q;
    rx_cnt_d = rx_cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    unique case (state_q)
      UNLOCKED: begin
        if (rx_next == COM_SYM) begin
          state_d  = LOCKED;
          rx_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          if (rx_next != COM_SYM) begin
            data_d  = rx_next;
            valid_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State, shift register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNLOCKED;
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_shift_q <= rx_next;
      rx_cnt_q   <= rx_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: rtl/pcie_tx_ser.sv
// MSB-first serializer with a free-running bit counter.
// Loads a word (or COM when idle) on the last bit slot.
module pcie_tx_ser
  import pcie_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              in_ready_o,
  output logic              serial_o
);

  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] tx_shift_d;
  logic [CNT_W-1:0]  tx_cnt_q;
  logic [CNT_W-1:0]  tx_cnt_d;
  logic              last;

  assign last       = (tx_cnt_q == CNT_LAST);
  assign in_ready_o = last;
  assign serial_o   = tx_shift_q[DATA_W-1];

  // Next shift/load value and counter wrap.
  always_comb begin
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_shift_d = tx_shift_q << 1;
    if (last) begin
      tx_cnt_d   = '0;
      tx_shift_d = valid_i ? data_i : COM_SYM;
    end
  end

  // Shift register and counter; reset idles on COM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= COM_SYM;
      tx_cnt_q   <= '0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

endmodule

// File: rtl/pcie_p2s2p_link.sv
// Loopback link: serializer feeding deserializer,
// serial line exposed for probing.
module pcie_p2s2p_link
  import pcie_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  pcie_p2s2p_link_if.slave   bus
);

  logic serial;

  assign bus.serial_out = serial;

  pcie_tx_ser u_tx (
    .clk        (CLK),
    .rst_n      (RESET),
    .valid_i    (bus.valid_in),
    .data_i     (bus.data_in),
    .in_ready_o (bus.in_ready),
    .serial_o   (serial)
  );

  pcie_rx_des u_rx (
    .clk      (CLK),
    .rst_n    (RESET),
    .serial_i (serial),
    .data_o   (bus.data_out),
    .valid_o  (bus.valid_out),
    .locked_o (bus.locked)
  );

endmodule

// File: tb/tb_pcie_p2s2p_link.sv
// Bench for the loopback link: word-stream model
// checked against every output every cycle.
module tb_pcie_p2s2p_link;
  import pcie_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  pcie_p2s2p_link_if bus();

  pcie_p2s2p_link dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  int n = 0;
  logic [7:0] words[$];
  logic [7:0] dexp = 8'h00;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h want %h n=%0d",
                tag, obs, exp, n);
  endtask

  // Cycle n: word n/8 on the line, bit 7-(n%8).
  // A word finishing at edge 8k is output after 8k.
  task automatic check_outputs();
    logic [7:0] w;
    logic s_e;
    logic v_e;
    w   = words[n / 8];
    s_e = w[7 - (n % 8)];
    v_e = 1'b0;
    if (n >= 16 && n % 8 == 0) begin
      w = words[n / 8 - 1];
      if (w != COM_SYM) begin
        v_e  = 1'b1;
        dexp = w;
      end
    end
    chk("serial", {7'b0, bus.serial_out}, {7'b0, s_e});
    chk("ready", {7'b0, bus.in_ready},
        {7'b0, (n % 8 == 7)});
    chk("locked", {7'b0, bus.locked}, {7'b0, (n >= 8)});
    chk("valid", {7'b0, bus.valid_out}, {7'b0, v_e});
    chk("data", bus.data_out, dexp);
  endtask

  task automatic step(input logic v,
                      input logic [7:0] d);
    check_outputs();
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge CLK);
    if (n % 8 == 7) words.push_back(v ? d : COM_SYM);
    n++;
    @(negedge CLK);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] d);
    while (n % 8 != 7) step(1'b0, 8'h00);
    step(1'b1, d);
  endtask

  task automatic do_reset(input int cyc);
    RESET = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    n = 0;
    words.delete();
    words.push_back(COM_SYM);
    dexp = 8'h00;
    check_outputs();
    repeat (cyc) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    @(negedge CLK);

    // reset and idle COM stream
    do_reset(3);
    idle(32);

    // single word at the first in_ready edge
    do_reset(3);
    idle(7);
    step(1'b1, 8'hA5);
    idle(16);

    // back-to-back stream
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    send(8'h81);
    idle(24);

    // alternate in_ready edges
    send(8'h11);
    idle(8);
    send(8'h22);
    idle(24);

    // reset mid-word
    do_reset(2);
    idle(7);
    step(1'b1, 8'h5A);
    idle(4);
    do_reset(3);
    idle(32);

    // valid held high, data changing every cycle
    for (int i = 0; i < 40; i++) begin
      r = 8'($urandom);
      if (r == COM_SYM) r = 8'h00;
      step(1'b1, r);
    end
    idle(16);

    // illegal COM data is delivered as idle
    send(COM_SYM);
    send(8'h7E);
    idle(24);

    // random traffic
    for (int i = 0; i < 240; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 15) == 0) r = COM_SYM;
      step(1'($urandom_range(0, 1)), r);
    end
    idle(24);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
